// File: rtl/gray_conv_pkg.sv
// Shared types and defaults for the Gray-to-binary conversion scheduler.
package gray_conv_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// searching upward with wrap.
module rr_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler feeding one bit-serial Gray-to-binary converter
// (MSB first, one bit per cycle) with a valid/ready result port.
module gray_conv_sched
    import gray_conv_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_binary,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);

    localparam int BW = $clog2(WIDTH);

    state_t           state;
    state_t           nstate;
    logic [BW-1:0]    idx;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH:0]   res_ext;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             bit_nx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (gidx)
    );

    // Bit above the MSB reads as zero so the MSB copies straight through.
    assign res_ext = {1'b0, res_q};
    assign bit_nx  = gray_q[idx] ^ res_ext[int'(idx) + 1];

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (|grant) nstate = CONV;
            CONV:    if (idx == '0) nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            gray_q <= '0;
            res_q  <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: if (|grant) begin
                    gray_q <= req_gray[int'(gidx)*WIDTH +: WIDTH];
                    id_q   <= gidx;
                    res_q  <= '0;
                    idx    <= BW'(WIDTH - 1);
                end
                CONV: begin
                    res_q[idx] <= bit_nx;
                    idx        <= idx - 1'b1;
                end
                DONE: if (out_ready) begin
                    rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Grants are masked by reset so nothing is offered while rst_n is low.
    assign req_ready  = (state == IDLE && rst_n) ? grant : '0;
    assign out_valid  = (state == DONE);
    assign out_binary = res_q;
    assign out_id     = id_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed scoreboard bench for gray_conv_sched (4x4 and 8-bit/3-requester).
module tb_gray_conv_sched;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int WB = 8;
    localparam int NB = 3;

    typedef struct {
        int          id;
        logic [31:0] bin;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_gray;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_binary;
    logic [1:0]    out_id;
    logic          busy;

    logic            rst_nb;
    logic [NB-1:0]   bvalid;
    logic [NB*WB-1:0] bgray;
    logic [NB-1:0]   bready;
    logic            bout_valid;
    logic            bout_ready;
    logic [WB-1:0]   bout_binary;
    logic [1:0]      bout_id;
    logic            bbusy;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];
    exp_t sbb[$];
    logic [W-1:0] words[N];

    gray_conv_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_id     (out_id),
        .busy       (busy)
    );

    gray_conv_sched #(.WIDTH(WB), .NREQ(NB)) dut_b (
        .clk        (clk),
        .rst_n      (rst_nb),
        .req_valid  (bvalid),
        .req_gray   (bgray),
        .req_ready  (bready),
        .out_valid  (bout_valid),
        .out_ready  (bout_ready),
        .out_binary (bout_binary),
        .out_id     (bout_id),
        .busy       (bbusy)
    );

    // Binary bit i is the parity of all Gray bits at or above i.
    function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
        logic [31:0] m;
        logic [31:0] b;
        m = (w >= 32) ? '1 : ((32'd1 << w) - 1);
        b = '0;
        for (int i = 0; i < w; i++) b[i] = ^((g & m) >> i);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic areq(input int id, input logic [W-1:0] g,
                        input logic [W-1:0] eb);
        req_gray[id*W +: W] = g;
        req_valid[id] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(1 << id));
        sb.push_back(exp_t'{id, 32'(eb)});
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_valid(input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(lat));
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'(sb.size()));
        end else begin
            e = sb.pop_front();
            check("binary", 32'(out_binary), e.bin);
            check("id", 32'(out_id), 32'(e.id));
        end
    endtask

    task automatic run(input int id, input logic [W-1:0] g,
                       input logic [W-1:0] eb);
        areq(id, g, eb);
        wait_valid(W);
        pop_check();
        @(negedge clk);
    endtask

    task automatic brun(input int id, input logic [WB-1:0] g,
                        input logic [WB-1:0] eb);
        int   n;
        exp_t e;
        bgray[id*WB +: WB] = g;
        bvalid[id] = 1'b1;
        #1;
        check("b_grant", 32'(bready), 32'(1 << id));
        sbb.push_back(exp_t'{id, 32'(eb)});
        @(posedge clk);
        @(negedge clk);
        bvalid[id] = 1'b0;
        n = 0;
        while (!bout_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", 32'(n), 32'(WB));
        e = sbb.pop_front();
        check("b_binary", 32'(bout_binary), e.bin);
        check("b_id", 32'(bout_id), 32'(e.id));
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0100;
        req_gray   = '0;
        out_ready  = 1'b1;
        rst_nb     = 1'b0;
        bvalid     = '0;
        bgray      = '0;
        bout_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bin", 32'(out_binary), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        rst_nb    = 1'b1;
        @(negedge clk);

        areq(2, 4'b1011, 4'b1101);
        check("busy_conv", 32'(busy), 32'd1);
        wait_valid(W);
        pop_check();
        @(negedge clk);

        run(0, 4'b0110, 4'b0100);
        run(0, 4'b1000, 4'b1111);
        run(0, 4'b0000, 4'b0000);
        for (int c = 0; c < 16; c++) run(0, W'(c), W'(g2b(32'(c), W)));

        rst_n = 1'b0;
        words = '{4'h3, 4'h5, 4'h9, 4'hE};
        for (int k = 0; k < N; k++) req_gray[k*W +: W] = words[k];
        req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % N;
            #1;
            check("rr_order", 32'(req_ready), 32'(1 << e));
            sb.push_back(exp_t'{e, g2b(32'(words[e]), W)});
            @(posedge clk);
            @(negedge clk);
            words[e] = words[e] + 4'd7;
            req_gray[e*W +: W] = words[e];
            wait_valid(W);
            pop_check();
            @(negedge clk);
        end
        req_valid = '0;

        out_ready = 1'b0;
        req_gray[1*W +: W] = 4'b1110;
        req_gray[3*W +: W] = 4'b0011;
        req_valid = 4'b1010;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        sb.push_back(exp_t'{1, 32'b1011});
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("no_grant_conv", 32'(req_ready), 32'd0);
        wait_valid(W);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold",
                  32'({req_ready, busy, out_valid, out_id, out_binary}),
                  32'({4'b0000, 1'b1, 1'b1, 2'd1, 4'b1011}));
        end
        out_ready = 1'b1;
        pop_check();
        @(negedge clk);
        #1;
        check("bp_next", 32'(req_ready), 32'b1000);
        sb.push_back(exp_t'{3, 32'b0010});
        @(posedge clk);
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_valid(W);
        pop_check();
        @(negedge clk);

        run(1, 4'b0001, 4'b0001);
        areq(2, 4'b0101, 4'b0110);
        req_valid[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst",
              32'({out_valid, req_ready, busy}), 32'd0);
        sb.delete();
        req_gray[0 +: W] = 4'b1100;
        req_valid[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        sb.push_back(exp_t'{0, 32'b1000});
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_valid(W);
        pop_check();
        @(negedge clk);
        #1;
        check("lost_grant", 32'(req_ready), 32'b0100);
        sb.push_back(exp_t'{2, 32'b0110});
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_valid(W);
        pop_check();
        @(negedge clk);

        brun(1, 8'b0000_0001, 8'b0000_0001);
        brun(2, 8'b1100_0000, 8'b1000_0000);
        bvalid[1] = 1'b1;
        bgray[1*WB +: WB] = 8'hFF;
        brun(0, 8'b0000_0011, 8'b0000_0010);
        bvalid[1] = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
